prog_tick_divider: RTL and testbench

Parametrised multi-channel clock divider for the digital clock datapath. Produces NCH independent clock-enable ticks and 50%-duty square waves from the 100 MHz system clock. Divisors are programmable at runtime through a valid/ready load port. Channels can be cascaded, for example ms → s → min, so one instance replaces the chain of fixed single-ratio dividers.

---
 rtl/prog_tick_divider.sv | 143 ++++++++++++++
 tb/tb_prog_tick_divider.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_tick_divider.sv
// prog_tick_divider: NCH-channel programmable clock-enable / square-wave
// divider. A single-slot valid/ready port loads new divisors at runtime.
// Channel i may count tick[i-1] instead of clock cycles (cascade).

// One divider channel: counter, active divisor, tick and square outputs.
module prog_tick_divider_ch #(
  parameter int CW      = 27,
  parameter int DIV_RST = 500000
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic          i_ev,
  input  logic          i_clr,
  input  logic          i_ld_hit,
  input  logic [CW-1:0] i_ld_div,
  output logic          o_tick,
  output logic          o_sq,
  output logic [CW-1:0] o_cnt,
  output logic          o_apply
);
  logic [CW-1:0] r_cnt, r_div;
  logic          r_tick, r_sq;
  logic [CW-1:0] w_last;
  logic          w_wrap;

  // divisors 0 and 1 both mean "wrap on every event"
  assign w_last  = (r_div > CW'(1)) ? r_div - CW'(1) : '0;
  assign w_wrap  = i_ev & (r_cnt >= w_last);
  // running channels swap divisor only at a wrap so the period never glitches;
  // frozen channels take it at once; sync_clr flushes it unconditionally
  assign o_apply = i_ld_hit & (i_clr | w_wrap | ~i_en);

  // counter / tick / square / divisor update
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_div  <= CW'(DIV_RST);
      r_tick <= 1'b0;
      r_sq   <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
      r_sq   <= 1'b0;
      if (i_ld_hit) r_div <= i_ld_div;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
      r_sq   <= ~r_sq;
      if (i_ld_hit) r_div <= i_ld_div;
    end else if (i_ev) begin
      r_cnt  <= r_cnt + CW'(1);
      r_tick <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      // a smaller divisor landing on a frozen channel must not strand cnt above it
      if (i_ld_hit && !i_en) begin
        r_div <= i_ld_div;
        if (i_ld_div <= r_cnt) r_cnt <= '0;
      end
    end
  end

  assign o_tick = r_tick;
  assign o_sq   = r_sq;
  assign o_cnt  = r_cnt;
endmodule

module prog_tick_divider #(
  parameter int NCH     = 3,
  parameter int CW      = 27,
  parameter int DIV_RST = 500000,
  parameter int CHW     = 3
) (
  input  logic              clk100Mhz,
  input  logic              rst_n,
  input  logic [NCH-1:0]    en,
  input  logic [NCH-1:0]    cascade,
  input  logic              sync_clr,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [CHW-1:0]    ld_ch,
  input  logic [CW-1:0]     ld_div,
  output logic [NCH-1:0]    tick,
  output logic [NCH-1:0]    sq,
  output logic [NCH*CW-1:0] cnt
);
  typedef struct packed {
    logic [CHW-1:0] ch;
    logic [CW-1:0]  div;
  } ld_req_t;

  // bit 0 of cascade has no upstream channel
  localparam logic [NCH-1:0] CASC_MASK = ~NCH'(1);

  ld_req_t                r_sh;
  logic                   r_pend;
  logic [NCH-1:0]         w_tick, w_sq, w_ev, w_hit, w_apply, w_tick_prev, w_casc;
  logic [NCH-1:0][CW-1:0] w_cnt;
  logic                   w_acc, w_ch_ok;

  assign w_tick_prev = NCH'({w_tick, 1'b0});
  assign w_casc      = cascade & CASC_MASK;
  assign w_ev        = en & (~w_casc | w_tick_prev);

  assign ld_ready = ~r_pend & ~sync_clr;
  assign w_acc    = ld_valid & ld_ready;
  assign w_ch_ok  = {1'b0, ld_ch} < (CHW+1)'(NCH);

  // shadow slot: out-of-range channels are accepted but never held
  always_ff @(posedge clk100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 1'b0;
      r_sh   <= '0;
    end else if (|w_apply) begin
      r_pend <= 1'b0;
    end else if (w_acc && w_ch_ok) begin
      r_pend <= 1'b1;
      r_sh   <= '{ch: ld_ch, div: ld_div};
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign w_hit[g] = r_pend & (r_sh.ch == CHW'(g));
    prog_tick_divider_ch #(.CW(CW), .DIV_RST(DIV_RST)) u_ch (
      .i_clk    (clk100Mhz),
      .i_rst_n  (rst_n),
      .i_en     (en[g]),
      .i_ev     (w_ev[g]),
      .i_clr    (sync_clr),
      .i_ld_hit (w_hit[g]),
      .i_ld_div (r_sh.div),
      .o_tick   (w_tick[g]),
      .o_sq     (w_sq[g]),
      .o_cnt    (w_cnt[g]),
      .o_apply  (w_apply[g])
    );
  end

  assign tick = w_tick;
  assign sq   = w_sq;
  assign cnt  = w_cnt;
endmodule

// File: tb/tb_prog_tick_divider.sv
// Randomized + directed bench for prog_tick_divider (NCH=3, CW=8, DIV_RST=4).
// A reference model steps once per clock and queues the expected outputs;
// a negedge monitor pops and compares them against the DUT.
module tb_prog_tick_divider;
  localparam int NCH = 3;
  localparam int CW  = 8;
  localparam int CHW = 3;

  logic              clk100Mhz = 1'b0;
  logic              rst_n     = 1'b0;
  logic [NCH-1:0]    en        = '0;
  logic [NCH-1:0]    cascade   = '0;
  logic              sync_clr  = 1'b0;
  logic              ld_valid  = 1'b0;
  logic [CHW-1:0]    ld_ch     = '0;
  logic [CW-1:0]     ld_div    = '0;
  logic              ld_ready;
  logic [NCH-1:0]    tick, sq;
  logic [NCH*CW-1:0] cnt;

  prog_tick_divider #(.NCH(NCH), .CW(CW), .DIV_RST(4), .CHW(CHW)) dut (
    .clk100Mhz(clk100Mhz), .rst_n(rst_n), .en(en), .cascade(cascade),
    .sync_clr(sync_clr), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_ch(ld_ch), .ld_div(ld_div), .tick(tick), .sq(sq), .cnt(cnt)
  );

  always #5 clk100Mhz = ~clk100Mhz;

  typedef struct {
    logic [NCH-1:0]    tick;
    logic [NCH-1:0]    sq;
    logic [NCH*CW-1:0] cnt;
    logic              rdy;
    int                cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_fail = 0, cyc = 0;

  // staged inputs, applied to the DUT just after each rising edge
  logic           d_rst = 1'b0, d_clr = 1'b0, d_vld = 1'b0;
  logic [NCH-1:0] d_en = '0, d_casc = '0;
  logic [CHW-1:0] d_ch = '0;
  logic [CW-1:0]  d_div = '0;

  // reference model state, in plain integers
  int m_cnt[NCH], m_div[NCH];
  bit m_tick[NCH], m_sq[NCH];
  bit m_pend;
  int m_sh_ch, m_sh_div;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = 0; m_div[i] = 4; m_tick[i] = 0; m_sq[i] = 0;
    end
    m_pend = 0;
  endtask

  // one clock of behaviour, evaluated from the inputs present at the edge
  task automatic model_step();
    bit prev[NCH];
    bit applied, rdy, ev, hit;
    int eff;
    applied = 0;
    rdy = !m_pend && !sync_clr;
    for (int i = 0; i < NCH; i++) prev[i] = m_tick[i];
    for (int i = 0; i < NCH; i++) begin
      eff = (m_div[i] == 0) ? 1 : m_div[i];
      ev  = en[i];
      if (i > 0 && cascade[i]) ev = en[i] && prev[i-1];
      hit = m_pend && (m_sh_ch == i);
      m_tick[i] = 0;
      if (sync_clr) begin
        m_cnt[i] = 0; m_sq[i] = 0;
        if (hit) begin m_div[i] = m_sh_div; applied = 1; end
      end else if (ev) begin
        if (m_cnt[i] + 1 >= eff) begin
          m_cnt[i] = 0; m_tick[i] = 1; m_sq[i] = !m_sq[i];
          if (hit) begin m_div[i] = m_sh_div; applied = 1; end
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end else if (hit && !en[i]) begin
        m_div[i] = m_sh_div; applied = 1;
        if (m_sh_div <= m_cnt[i]) m_cnt[i] = 0;
      end
    end
    if (applied) m_pend = 0;
    if (ld_valid && rdy) begin
      if (int'(ld_ch) < NCH) begin
        m_pend = 1; m_sh_ch = int'(ld_ch); m_sh_div = int'(ld_div);
      end
      d_vld = 1'b0;  // request taken: driver withdraws it
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.tick = '0; e.sq = '0; e.cnt = '0;
    for (int i = 0; i < NCH; i++) begin
      e.tick[i] = m_tick[i];
      e.sq[i]   = m_sq[i];
      e.cnt[i*CW +: CW] = CW'(m_cnt[i]);
    end
    e.rdy = !m_pend && !sync_clr;
    e.cyc = cyc;
    q.push_back(e);
  endtask

  task automatic cycle();
    @(posedge clk100Mhz);
    if (!rst_n) model_reset(); else model_step();
    #1;
    rst_n = d_rst; en = d_en; cascade = d_casc; sync_clr = d_clr;
    ld_valid = d_vld; ld_ch = d_ch; ld_div = d_div;
    if (!rst_n) model_reset();
    push_exp();
    cyc++;
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic clr_pulse();
    d_clr = 1'b1; cycle(); d_clr = 1'b0;
  endtask

  // hold a request until the model reports it accepted (bounded)
  task automatic do_load(int ch, int dv);
    int k;
    d_vld = 1'b1; d_ch = CHW'(ch); d_div = CW'(dv);
    for (k = 0; k < 300 && d_vld; k++) cycle();
    if (d_vld) begin
      n_cmp++; n_fail++;
      $display("FAIL load_accept ch=%0d got=not_accepted want=accepted", ch);
      d_vld = 1'b0; cycle();
    end
  endtask

  task automatic wait_cnt(int ch, int val);
    int k;
    for (k = 0; k < 300 && m_cnt[ch] != val; k++) cycle();
    if (m_cnt[ch] != val) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_cnt ch=%0d got=%0d want=%0d", ch, m_cnt[ch], val);
    end
  endtask

  task automatic chk(string name, int c, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, c, got, want);
    end
  endtask

  // monitor: compares queued expectations away from the active edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk100Mhz);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("tick",     e.cyc, 32'(tick),     32'(e.tick));
        chk("sq",       e.cyc, 32'(sq),       32'(e.sq));
        chk("cnt",      e.cyc, 32'(cnt),      32'(e.cnt));
        chk("ld_ready", e.cyc, 32'(ld_ready), 32'(e.rdy));
      end
    end
  end

  initial begin
    model_reset();
    run(3);
    // reset release, channel 0 only at the reset divisor
    d_rst = 1'b1; d_en = 3'b001;
    run(24);
    // cascade chain, all divisors 4
    d_en = 3'b111; d_casc = 3'b110;
    clr_pulse();
    run(140);
    // runtime load to running channel 0
    wait_cnt(0, 0);
    do_load(0, 6);
    run(30);
    // load to a frozen channel with cnt above the new divisor
    d_casc = 3'b000; d_en = 3'b011;
    clr_pulse();
    wait_cnt(1, 2);
    d_en = 3'b001; cycle();
    do_load(1, 2);
    run(5);
    do_load(1, 0);
    d_en = 3'b011;
    run(10);
    // back-to-back requests, out-of-range channel, sync_clr with load pending
    d_en = 3'b111;
    do_load(2, 7);
    do_load(2, 3);
    do_load(5, 1);
    run(10);
    do_load(0, 9);
    clr_pulse();
    run(30);
    // randomized phase
    for (int k = 0; k < 3000; k++) begin
      if (k % 64 == 0) d_casc = NCH'($urandom_range(0, 7));
      d_en  = ($urandom_range(0, 3) == 0) ? NCH'($urandom_range(0, 7)) : '1;
      d_clr = ($urandom_range(0, 49) == 0);
      if (!d_vld && $urandom_range(0, 7) == 0) begin
        d_vld = 1'b1;
        d_ch  = CHW'($urandom_range(0, 7));
        d_div = CW'($urandom_range(0, 9));
      end
      cycle();
    end
    d_vld = 1'b0; d_clr = 1'b0;
    // full-scale divisor on channel 2
    d_en = 3'b111; d_casc = 3'b000;
    clr_pulse();
    d_en = 3'b100;
    do_load(2, 255);
    run(600);
    // async reset mid-count with a load pending
    d_en = 3'b111;
    do_load(2, 9);
    run(3);
    d_rst = 1'b0; run(3);
    d_rst = 1'b1; d_en = 3'b001;
    run(20);
    repeat (3) @(posedge clk100Mhz);
    if (q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
